// File: rtl/btn_pkg.sv
// Shared definitions for the push-button front end: channel FSM encoding,
// button index constants and a width helper.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int BTN_UP     = 0;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_MIDDLE = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_DOWN   = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM, long-press timer.
// Optional auto-repeat of btn_press after a long press: BTN_AUTO_REPEAT_EN.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 2_000_000,
    parameter int LONG_CYC     = 300_000_000,
    parameter int REPEAT_CYC   = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_raw,
    output logic       o_level,
    output logic       o_press,
    output logic       o_release,
    output logic       o_long,
    output btn_state_t o_state
);

    localparam int CW = $clog2(max3(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC) + 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] LONG_SAT  = CW'(LONG_CYC);

    logic [1:0]    r_sync;
    btn_state_t    r_state, w_state_n;
    logic [CW-1:0] r_deb, w_deb_n;
    logic [CW-1:0] r_hold, w_hold_n;
    logic          r_long_done, w_long_done_n;
    logic          r_level, w_level_n;
    logic          r_press, w_press_n;
    logic          r_release, w_release_n;
    logic          r_long, w_long_n;
    logic          w_s;
`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYC - 1);
    logic [CW-1:0] r_rep, w_rep_n;
`endif

    assign w_s = r_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync      <= 2'b00;
            r_state     <= IDLE;
            r_deb       <= '0;
            r_hold      <= '0;
            r_long_done <= 1'b0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            r_rep       <= '0;
`endif
        end else begin
            r_sync      <= {r_sync[0], i_raw};
            r_state     <= w_state_n;
            r_deb       <= w_deb_n;
            r_hold      <= w_hold_n;
            r_long_done <= w_long_done_n;
            r_level     <= w_level_n;
            r_press     <= w_press_n;
            r_release   <= w_release_n;
            r_long      <= w_long_n;
`ifdef BTN_AUTO_REPEAT_EN
            r_rep       <= w_rep_n;
`endif
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_deb_n       = r_deb;
        w_hold_n      = r_hold;
        w_long_done_n = r_long_done;
        w_level_n     = r_level;
        w_press_n     = 1'b0;
        w_release_n   = 1'b0;
        w_long_n      = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
        w_rep_n       = r_rep;
`endif
        unique case (r_state)
            IDLE: begin
                if (w_s) begin
                    w_state_n = PRESS_WAIT;
                    w_deb_n   = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!w_s) begin
                    w_state_n = IDLE;
                end else if (r_deb == DEB_LAST) begin
                    w_state_n     = HELD;
                    w_press_n     = 1'b1;
                    w_level_n     = 1'b1;
                    w_hold_n      = '0;
                    w_long_done_n = 1'b0;
                end else begin
                    w_deb_n = r_deb + 1'b1;
                end
            end
            HELD: begin
                if (!w_s) begin
                    w_state_n = RELEASE_WAIT;
                    w_deb_n   = CW'(1);
                end
            end
            RELEASE_WAIT: begin
                if (w_s) begin
                    w_state_n = HELD;
                end else if (r_deb == DEB_LAST) begin
                    w_state_n   = IDLE;
                    w_release_n = 1'b1;
                    w_level_n   = 1'b0;
                end else begin
                    w_deb_n = r_deb + 1'b1;
                end
            end
        endcase

        // Hold time keeps running through a release bounce so a due long pulse still fires.
        if (r_state == HELD || r_state == RELEASE_WAIT) begin
            if (r_hold != LONG_SAT) w_hold_n = r_hold + 1'b1;
            if (r_hold == LONG_LAST && !r_long_done) begin
                w_long_n      = 1'b1;
                w_long_done_n = 1'b1;
            end
        end

`ifdef BTN_AUTO_REPEAT_EN
        if (w_long_n) begin
            w_rep_n = '0;
        end else if (r_state == HELD) begin
            if (!w_s) begin
                w_rep_n = '0;
            end else if (r_long_done) begin
                if (r_rep == REP_LAST) begin
                    w_rep_n   = '0;
                    w_press_n = 1'b1;
                end else begin
                    w_rep_n = r_rep + 1'b1;
                end
            end
        end
`endif
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;
    assign o_state   = r_state;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end: N_BTN independent debounced channels.
// Build option BTN_AUTO_REPEAT_EN enables press auto-repeat after a long press.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN        = BTN_DOWN + 1,
    parameter int DEBOUNCE_CYC = 2_000_000,
    parameter int LONG_CYC     = 300_000_000,
    parameter int REPEAT_CYC   = 25_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_BTN-1:0]   btn_raw,
    output logic [N_BTN-1:0]   btn_level,
    output logic [N_BTN-1:0]   btn_press,
    output logic [N_BTN-1:0]   btn_release,
    output logic [N_BTN-1:0]   btn_long,
    output logic [2*N_BTN-1:0] dbg_state
);

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
        btn_state_t w_state;

        btn_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC),
            .REPEAT_CYC   (REPEAT_CYC)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_raw     (btn_raw[gi]),
            .o_level   (btn_level[gi]),
            .o_press   (btn_press[gi]),
            .o_release (btn_release[gi]),
            .o_long    (btn_long[gi]),
            .o_state   (w_state)
        );

        assign dbg_state[2*gi +: 2] = w_state;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random pin activity,
// checked every cycle against an event-rule reference model.
module tb_btn_conditioner;

    localparam int N    = 5;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 5;
    localparam int MAXC = 4096;
`ifdef BTN_AUTO_REPEAT_EN
    localparam int REP_PRESSES = 4;
`else
    localparam int REP_PRESSES = 1;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   btn_raw, btn_level, btn_press, btn_release, btn_long;
    logic [2*N-1:0] dbg_state;

    always #5 clk = ~clk;

    btn_conditioner #(
        .N_BTN(N), .DEBOUNCE_CYC(DEB), .LONG_CYC(LONG), .REPEAT_CYC(REP)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level),
        .btn_press(btn_press), .btn_release(btn_release), .btn_long(btn_long),
        .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [N-1:0] raw_h [MAXC];
    bit           rst_h [MAXC];

    // Model: accepted level, cycle of last level change, press/long/repeat cycles.
    bit m_lvl [N];
    int m_lc [N], m_pc [N], m_long [N], m_rep [N];

    int press_cnt [N], rel_cnt [N], long_cnt [N];
    int last_press [N], last_rel [N], last_long [N];
    logic [N-1:0] first_pv, first_rv;

    function automatic bit s_at(input int ch, input int c);
        if (c < 2) return 1'b0;
        if (rst_h[c-1] || rst_h[c-2]) return 1'b0;
        return raw_h[c-2][ch];
    endfunction

    function automatic bit run_of(input int ch, input int from, input int to, input bit v);
        for (int k = from; k <= to; k++)
            if (s_at(ch, k) != v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: got %0h, want %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_and_check();
        logic [N-1:0] e_lvl, e_pr, e_rl, e_lg;
        int c, anchor, lastzero;
        c = cyc;
        e_pr = '0; e_rl = '0; e_lg = '0;
        for (int ch = 0; ch < N; ch++) begin
            if (rst_h[c-1]) begin
                m_lvl[ch] = 1'b0;
                m_lc[ch]  = c;
            end else if (!m_lvl[ch]) begin
                if (c - DEB >= m_lc[ch] && run_of(ch, c - DEB, c - 1, 1'b1)) begin
                    e_pr[ch] = 1'b1;
                    m_lvl[ch] = 1'b1; m_lc[ch] = c; m_pc[ch] = c;
                    m_long[ch] = -1000; m_rep[ch] = -1000;
                end
            end else begin
                e_lg[ch] = (c - m_pc[ch] == LONG);
`ifdef BTN_AUTO_REPEAT_EN
                if (m_long[ch] >= 0) begin
                    lastzero = -1000;
                    for (int k = m_pc[ch]; k < c; k++)
                        if (!s_at(ch, k)) lastzero = k;
                    anchor = m_long[ch];
                    if (m_rep[ch] > anchor) anchor = m_rep[ch];
                    if (lastzero + 2 > anchor) anchor = lastzero + 2;
                    if (c - anchor == REP && run_of(ch, anchor, c - 1, 1'b1)) begin
                        e_pr[ch] = 1'b1;
                        m_rep[ch] = c;
                    end
                end
`endif
                if (c - DEB >= m_lc[ch] && run_of(ch, c - DEB, c - 1, 1'b0)) begin
                    e_rl[ch] = 1'b1;
                    m_lvl[ch] = 1'b0; m_lc[ch] = c;
                end
                if (e_lg[ch]) m_long[ch] = c;
            end
            e_lvl[ch] = m_lvl[ch];
        end
        check("level", 32'(btn_level), 32'(e_lvl));
        check("press", 32'(btn_press), 32'(e_pr));
        check("release", 32'(btn_release), 32'(e_rl));
        check("long", 32'(btn_long), 32'(e_lg));
        if (rst_h[c-1]) check("dbg_state_reset", 32'(dbg_state), 32'd0);
    endtask

    task automatic monitor();
        for (int ch = 0; ch < N; ch++) begin
            if (btn_press[ch])   begin press_cnt[ch]++; last_press[ch] = cyc; end
            if (btn_release[ch]) begin rel_cnt[ch]++;   last_rel[ch]   = cyc; end
            if (btn_long[ch])    begin long_cnt[ch]++;  last_long[ch]  = cyc; end
        end
        if (first_pv == '0 && btn_press != '0)   first_pv = btn_press;
        if (first_rv == '0 && btn_release != '0) first_rv = btn_release;
    endtask

    task automatic clear_counts();
        for (int ch = 0; ch < N; ch++) begin
            press_cnt[ch] = 0; rel_cnt[ch] = 0; long_cnt[ch] = 0;
            last_press[ch] = -1; last_rel[ch] = -1; last_long[ch] = -1;
        end
        first_pv = '0; first_rv = '0;
    endtask

    task automatic tick(input logic [N-1:0] raw, input bit r);
        @(posedge clk);
        cyc++;
        #1;
        model_and_check();
        monitor();
        btn_raw = raw; rst = r;
        raw_h[cyc] = raw; rst_h[cyc] = r;
    endtask

    task automatic drive(input int n, input logic [N-1:0] raw, input bit r);
        for (int i = 0; i < n; i++) tick(raw, r);
    endtask

    initial begin
        int t0, tr;
        logic [N-1:0] v;
        btn_raw = '0; rst = 1'b1;
        raw_h[0] = '0; rst_h[0] = 1'b1;
        for (int ch = 0; ch < N; ch++) begin
            m_lvl[ch] = 1'b0; m_lc[ch] = 0; m_pc[ch] = 0; m_long[ch] = -1000; m_rep[ch] = -1000;
        end
        clear_counts();

        drive(3, '0, 1'b1);
        drive(5, '0, 1'b0);

        // Clean press on middle
        clear_counts(); t0 = cyc + 1;
        drive(12, 5'b00100, 1'b0);
        drive(10, 5'b00000, 1'b0);
        check("clean_press_cnt", press_cnt[2], 1);
        check("clean_press_lat", last_press[2] - t0, DEB + 2);
        check("clean_rel_cnt", rel_cnt[2], 1);
        check("clean_rel_lat", last_rel[2] - (t0 + 12), DEB + 2);
        check("clean_long_cnt", long_cnt[2], 0);

        // Short bounce rejected, then a 2-cycle glitch inside a hold
        clear_counts();
        drive(3, 5'b00001, 1'b0);
        drive(10, 5'b00000, 1'b0);
        check("bounce_press_cnt", press_cnt[0], 0);
        drive(8, 5'b00001, 1'b0);
        drive(2, 5'b00000, 1'b0);
        drive(6, 5'b00001, 1'b0);
        drive(10, 5'b00000, 1'b0);
        check("glitch_press_cnt", press_cnt[0], 1);
        check("glitch_rel_cnt", rel_cnt[0], 1);

        // Long press on left, then a short hold with no long pulse
        clear_counts(); t0 = cyc + 1;
        drive(30, 5'b00010, 1'b0);
        drive(10, 5'b00000, 1'b0);
        check("long_cnt", long_cnt[1], 1);
        check("long_lat", last_long[1] - t0, DEB + 2 + LONG);
        check("long_rel_lat", last_rel[1] - (t0 + 30), DEB + 2);
        clear_counts();
        drive(10, 5'b00010, 1'b0);
        drive(10, 5'b00000, 1'b0);
        check("short_long_cnt", long_cnt[1], 0);
        check("short_press_cnt", press_cnt[1], 1);

        // Simultaneous press on left and right, left released first
        clear_counts();
        drive(8, 5'b01010, 1'b0);
        drive(8, 5'b01000, 1'b0);
        drive(12, 5'b00000, 1'b0);
        check("simul_press_vec", 32'(first_pv), 32'(5'b01010));
        check("simul_rel_vec", 32'(first_rv), 32'(5'b00010));

        // Reset while down is held; pin stays high through reset
        clear_counts();
        drive(10, 5'b10000, 1'b0);
        tr = cyc + 1;
        drive(1, 5'b10000, 1'b1);
        drive(12, 5'b10000, 1'b0);
        check("rst_rel_cnt", rel_cnt[4], 0);
        check("rst_press_cnt", press_cnt[4], 2);
        check("rst_repress_lat", last_press[4] - tr, DEB + 3);
        drive(10, 5'b00000, 1'b0);

        // 40-cycle hold on right: repeats only when the option is built in
        clear_counts();
        drive(40, 5'b01000, 1'b0);
        drive(10, 5'b00000, 1'b0);
        check("hold40_press_cnt", press_cnt[3], REP_PRESSES);
        check("hold40_long_cnt", long_cnt[3], 1);

        // Random pins: bouncy phase then slow phase, occasional reset
        v = '0;
        for (int i = 0; i < 900; i++) begin
            for (int ch = 0; ch < N; ch++)
                if ($urandom_range(0, (i < 400) ? 3 : 29) == 0) v[ch] = ~v[ch];
            tick(v, ($urandom_range(0, 199) == 0));
        end
        drive(12, 5'b00000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
